// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU (logic ops, add/sub, shifts).
// Define ALU_PIPE_FLAGS_EN to build the registered {N,Z,C,V} flag path; otherwise flags is tied to 0.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic [3:0]       flags
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam logic [WIDTH:0] SHIFT_LIMIT = (WIDTH+1)'(WIDTH);

  logic             r_s1Valid;
  logic [WIDTH-1:0] r_s1A;
  logic [WIDTH-1:0] r_s1B;
  logic [2:0]       r_s1Op;
  logic             r_outValid;
  logic [WIDTH-1:0] r_o;

  logic             w_s1Load;
  logic             w_s2Load;
  logic             w_shiftOver;
  logic [WIDTH-1:0] w_addRes;
  logic [WIDTH-1:0] w_subRes;
  logic [WIDTH-1:0] w_result;

  // S2 frees up when its result is absent or being taken; in_ready follows out_ready combinationally.
  assign w_s2Load    = r_s1Valid && (!r_outValid || out_ready);
  assign in_ready    = !r_s1Valid || w_s2Load;
  assign w_s1Load    = in_valid && in_ready;
  assign w_shiftOver = ({1'b0, r_s1B} >= SHIFT_LIMIT);

`ifdef ALU_PIPE_FLAGS_EN
  logic [WIDTH:0] w_addExt;
  logic [WIDTH:0] w_subExt;
  assign w_addExt = {1'b0, r_s1A} + {1'b0, r_s1B};
  assign w_subExt = {1'b0, r_s1A} - {1'b0, r_s1B};
  assign w_addRes = w_addExt[WIDTH-1:0];
  assign w_subRes = w_subExt[WIDTH-1:0];
`else
  assign w_addRes = r_s1A + r_s1B;
  assign w_subRes = r_s1A - r_s1B;
`endif

  always_comb begin
    w_result = '0;
    case (r_s1Op)
      OP_AND: w_result = r_s1A & r_s1B;
      OP_NOT: w_result = ~r_s1A;
      OP_XOR: w_result = r_s1A ^ r_s1B;
      OP_OR:  w_result = r_s1A | r_s1B;
      OP_ADD: w_result = w_addRes;
      OP_SUB: w_result = w_subRes;
      OP_SHL: w_result = w_shiftOver ? '0 : (r_s1A << r_s1B);
      OP_SHR: w_result = w_shiftOver ? '0 : (r_s1A >> r_s1B);
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1A     <= '0;
      r_s1B     <= '0;
      r_s1Op    <= '0;
    end else begin
      r_s1Valid <= w_s1Load || (r_s1Valid && !w_s2Load);
      if (w_s1Load) begin
        r_s1A  <= in1;
        r_s1B  <= in2;
        r_s1Op <= opcode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_o        <= '0;
    end else begin
      if (w_s2Load) begin
        r_outValid <= 1'b1;
        r_o        <= w_result;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_valid = r_outValid;
  assign o         = r_o;

`ifdef ALU_PIPE_FLAGS_EN
  logic       w_carry;
  logic       w_overflow;
  logic [3:0] w_flags;
  logic [3:0] r_flags;

  // For SUB the carry bit of the extended difference is the borrow (in1 < in2).
  always_comb begin
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (r_s1Op)
      OP_ADD: begin
        w_carry    = w_addExt[WIDTH];
        w_overflow = (r_s1A[WIDTH-1] == r_s1B[WIDTH-1]) &&
                     (w_addRes[WIDTH-1] != r_s1A[WIDTH-1]);
      end
      OP_SUB: begin
        w_carry    = w_subExt[WIDTH];
        w_overflow = (r_s1A[WIDTH-1] != r_s1B[WIDTH-1]) &&
                     (w_subRes[WIDTH-1] != r_s1A[WIDTH-1]);
      end
      default: begin
        w_carry    = 1'b0;
        w_overflow = 1'b0;
      end
    endcase
  end

  assign w_flags = {w_result[WIDTH-1], (w_result == '0), w_carry, w_overflow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0100;
    end else if (w_s2Load) begin
      r_flags <= w_flags;
    end
  end

  assign flags = r_flags;
`else
  assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (8-bit and 16-bit instances).
// Flag expectations follow ALU_PIPE_FLAGS_EN; without it flags must read 4'b0000.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic [2:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  o;
  logic [3:0]  flags;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] in1_16;
  logic [15:0] in2_16;
  logic [2:0]  opcode16;
  logic        out_valid16;
  logic        out_ready16;
  logic [15:0] o16;
  logic [3:0]  flags16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .flags(flags)
  );

  alu_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in1(in1_16), .in2(in2_16), .opcode(opcode16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .o(o16), .flags(flags16)
  );

  function automatic logic [3:0] expFlags(input logic [3:0] f);
`ifdef ALU_PIPE_FLAGS_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic run_single8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1; in1 = a; in2 = b; opcode = op; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_single16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    in_valid16 = 1'b1; in1_16 = a; in2_16 = b; opcode16 = op; out_ready16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in1 = '0; in2 = '0; opcode = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; in1_16 = '0; in2_16 = '0; opcode16 = '0; out_ready16 = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (o !== 8'h00) begin failures++; $display("[TB] FAIL reset_o: got %h expected 00", o); end
    checks++; if (flags !== expFlags(4'b0100)) begin failures++; $display("[TB] FAIL reset_flags: got %b expected %b", flags, expFlags(4'b0100)); end
    checks++; if (flags16 !== expFlags(4'b0100)) begin failures++; $display("[TB] FAIL reset_flags16: got %b expected %b", flags16, expFlags(4'b0100)); end
    checks++; if (out_valid16 !== 1'b0 || o16 !== 16'h0000) begin failures++; $display("[TB] FAIL reset_dut16: got valid=%b o=%h expected valid=0 o=0000", out_valid16, o16); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add_single();
    @(posedge clk); #1;
    in_valid = 1'b1; in1 = 8'hFF; in2 = 8'h01; opcode = 3'b100; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL add_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_early_valid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_latency_valid: got %b expected 1", out_valid); end
    checks++; if (o !== 8'h00) begin failures++; $display("[TB] FAIL add_o: got %h expected 00", o); end
    checks++; if (flags !== expFlags(4'b0110)) begin failures++; $display("[TB] FAIL add_flags: got %b expected %b", flags, expFlags(4'b0110)); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_valid_one_cycle: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [4];
    logic [7:0] expO [4];
    logic [3:0] expF [4];
    ops  = '{3'b000, 3'b001, 3'b010, 3'b011};
    expO = '{8'h88, 8'h33, 8'h66, 8'hEE};
    expF = '{4'b1000, 4'b0000, 4'b0000, 4'b1000};
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in1 = 8'hCC; in2 = 8'hAA; opcode = ops[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i >= 1) begin
        checks++; if (out_valid !== 1'b1 || o !== expO[i-1]) begin failures++; $display("[TB] FAIL legacy_op%0d: got valid=%b o=%h expected valid=1 o=%h", i-1, out_valid, o, expO[i-1]); end
        checks++; if (flags !== expFlags(expF[i-1])) begin failures++; $display("[TB] FAIL legacy_flags%0d: got %b expected %b", i-1, flags, expFlags(expF[i-1])); end
      end
      if (i + 1 < 4) opcode = ops[i+1];
      else in_valid = 1'b0;
    end
  endtask

  task automatic test_arith_shift();
    logic [2:0] ops  [10];
    logic [7:0] aV   [10];
    logic [7:0] bV   [10];
    logic [7:0] expO [10];
    logic [3:0] expF [10];
    ops  = '{3'b101, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b100, 3'b101, 3'b100, 3'b101};
    aV   = '{8'h80,  8'hFF,  8'hFF,  8'hFF,  8'h80,  8'hFF,  8'h7F,  8'h01,  8'hFF,  8'h05};
    bV   = '{8'h01,  8'h09,  8'h08,  8'h07,  8'h07,  8'h08,  8'h01,  8'h02,  8'hFF,  8'h05};
    expO = '{8'h7F,  8'h00,  8'h00,  8'h80,  8'h01,  8'h00,  8'h80,  8'hFF,  8'hFE,  8'h00};
    expF = '{4'b0001, 4'b0100, 4'b0100, 4'b1000, 4'b0000, 4'b0100, 4'b1001, 4'b1010, 4'b1010, 4'b0100};
    for (int i = 0; i < 10; i++) begin
      run_single8(ops[i], aV[i], bV[i]);
      checks++; if (out_valid !== 1'b1 || o !== expO[i]) begin failures++; $display("[TB] FAIL arith%0d_o: got valid=%b o=%h expected valid=1 o=%h", i, out_valid, o, expO[i]); end
      checks++; if (flags !== expFlags(expF[i])) begin failures++; $display("[TB] FAIL arith%0d_flags: got %b expected %b", i, flags, expFlags(expF[i])); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] expO [5];
    logic [7:0] got  [5];
    int acc;
    int rcv;
    logic take;
    logic give;
    for (int k = 0; k < 5; k++) begin
      expO[k] = 8'(10 + 2 * k);
      got[k]  = 8'h00;
    end
    acc = 0;
    rcv = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in1 = 8'd10; in2 = 8'd0; opcode = 3'b100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) begin
        acc++;
        if (acc < 5) begin in1 = 8'(10 + acc); in2 = 8'(acc); end
      end
    end
    checks++; if (acc !== 2) begin failures++; $display("[TB] FAIL bp_accepted: got %0d expected 2", acc); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready_full: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || o !== expO[0]) begin failures++; $display("[TB] FAIL bp_head: got valid=%b o=%h expected valid=1 o=%h", out_valid, o, expO[0]); end
    @(posedge clk); #1;
    checks++; if (o !== expO[0] || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_stall_hold: got valid=%b o=%h expected valid=1 o=%h", out_valid, o, expO[0]); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_comb: got %b expected 1", in_ready); end
    for (int c = 0; c < 40 && rcv < 5; c++) begin
      @(negedge clk);
      take = in_valid && in_ready;
      give = out_valid && out_ready;
      if (give) begin got[rcv] = o; rcv++; end
      @(posedge clk); #1;
      if (take) begin
        acc++;
        if (acc < 5) begin in1 = 8'(10 + acc); in2 = 8'(acc); end
        else in_valid = 1'b0;
      end
    end
    checks++; if (rcv !== 5 || acc !== 5) begin failures++; $display("[TB] FAIL bp_counts: got received=%0d accepted=%0d expected 5 and 5", rcv, acc); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (got[k] !== expO[k]) begin failures++; $display("[TB] FAIL bp_order%0d: got %h expected %h", k, got[k], expO[k]); end
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_no_dup: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in1 = 8'h5A; in2 = 8'h0F; opcode = 3'b010;
    @(posedge clk); #1;
    in1 = 8'h11; in2 = 8'h00; opcode = 3'b011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || o !== 8'h55) begin failures++; $display("[TB] FAIL midrst_pre: got valid=%b o=%h expected valid=1 o=55", out_valid, o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_async_valid: got %b expected 0", out_valid); end
    checks++; if (o !== 8'h00 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_state: got o=%h in_ready=%b expected o=00 in_ready=1", o, in_ready); end
    checks++; if (flags !== expFlags(4'b0100)) begin failures++; $display("[TB] FAIL midrst_flags: got %b expected %b", flags, expFlags(4'b0100)); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_stale%0d: got valid=%b o=%h expected valid=0", c, out_valid, o); end
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in1 = 8'h03; in2 = 8'h04; opcode = 3'b100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_early: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || o !== 8'h07) begin failures++; $display("[TB] FAIL midrst_new_beat: got valid=%b o=%h expected valid=1 o=07", out_valid, o); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_after: got %b expected 0", out_valid); end
  endtask

  task automatic test_width16();
    logic [2:0]  ops  [4];
    logic [15:0] aV   [4];
    logic [15:0] bV   [4];
    logic [15:0] expO [4];
    logic [3:0]  expF [4];
    ops  = '{3'b100,   3'b110,   3'b110,   3'b111};
    aV   = '{16'h7FFF, 16'h0001, 16'hFFFF, 16'h8000};
    bV   = '{16'h0001, 16'h000F, 16'h0010, 16'h000F};
    expO = '{16'h8000, 16'h8000, 16'h0000, 16'h0001};
    expF = '{4'b1001,  4'b1000,  4'b0100,  4'b0000};
    for (int i = 0; i < 4; i++) begin
      run_single16(ops[i], aV[i], bV[i]);
      checks++; if (out_valid16 !== 1'b1 || o16 !== expO[i]) begin failures++; $display("[TB] FAIL w16_%0d_o: got valid=%b o=%h expected valid=1 o=%h", i, out_valid16, o16, expO[i]); end
      checks++; if (flags16 !== expFlags(expF[i])) begin failures++; $display("[TB] FAIL w16_%0d_flags: got %b expected %b", i, flags16, expFlags(expF[i])); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_add_single();
    test_back_to_back();
    test_arith_shift();
    test_backpressure();
    test_reset_midflight();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
